// File: rtl/mesh_link_qbuf.sv
`timescale 1ns/1ps
// mesh_link_qbuf: one buffered, directional hop between neighbouring mesh
// nodes. Packets are split into two class FIFOs by their QoS bit. A
// starvation-limited arbiter drains them into a single registered output
// stage with valid/ready handshake. When the link goes down, input is
// refused. Optionally, the FIFOs are flushed and the discarded packets are
// counted.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   link_en          link up when 1
//   in_vld/in_pkt    upstream packet; in_rdy = may transfer this cycle
//   out_vld/out_pkt  registered downstream packet; out_rdy = accepted
//   occ_hi/occ_lo    per-class FIFO occupancy
//   drop_cnt         saturating count of packets discarded by flushes
module mesh_link_qbuf #(
  parameter int PKT_W         = 23,
  parameter int QOS_BIT       = 20,
  parameter int DEPTH         = 4,
  parameter int STARVE_MAX    = 8,
  parameter int FLUSH_ON_DOWN = 1,
  parameter int CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       link_en,
  input  logic                       in_vld,
  input  logic [PKT_W-1:0]           in_pkt,
  output logic                       in_rdy,
  output logic                       out_vld,
  output logic [PKT_W-1:0]           out_pkt,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] occ_hi,
  output logic [$clog2(DEPTH+1)-1:0] occ_lo,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ADD_W = OCC_W + 1;
  localparam int SUM_W = ((CNT_W > ADD_W) ? CNT_W : ADD_W) + 1;
  localparam logic [OCC_W-1:0] FULL_CNT   = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [7:0]       STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [PKT_W-1:0] hi_mem_q [DEPTH];
  logic [PKT_W-1:0] lo_mem_q [DEPTH];
  logic [PTR_W-1:0] hi_wr_q, hi_wr_d, hi_rd_q, hi_rd_d;
  logic [PTR_W-1:0] lo_wr_q, lo_wr_d, lo_rd_q, lo_rd_d;
  logic [OCC_W-1:0] hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
  logic             out_vld_q, out_vld_d;
  logic [PKT_W-1:0] out_pkt_q, out_pkt_d;
  logic [7:0]       starve_q, starve_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             link_q;

  logic             cls, hi_ne, lo_ne, push, out_free, bypass;
  logic             wr_hi, wr_lo, grant_lo, pop_hi, pop_lo, flush;
  logic [ADD_W-1:0] drop_add;
  logic [SUM_W-1:0] drop_sum;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    cls      = in_pkt[QOS_BIT];
    hi_ne    = (hi_cnt_q != '0);
    lo_ne    = (lo_cnt_q != '0);
    // Readiness uses pre-pop fullness of the addressed class.
    in_rdy   = link_en && (cls ? (hi_cnt_q != FULL_CNT) : (lo_cnt_q != FULL_CNT));
    push     = in_vld && in_rdy;
    out_free = !out_vld_q || out_rdy;
    // With both FIFOs empty, an incoming packet goes straight to the output
    // register, which gives one-cycle latency through an idle link.
    bypass   = push && out_free && !hi_ne && !lo_ne;
    wr_hi    = push && cls && !bypass;
    wr_lo    = push && !cls && !bypass;
    grant_lo = lo_ne && (!hi_ne || (starve_q == STARVE_LIM));
    pop_lo   = out_free && grant_lo;
    pop_hi   = out_free && hi_ne && !grant_lo;
    flush    = (FLUSH_ON_DOWN != 0) && link_q && !link_en;

    hi_wr_d  = wr_hi  ? ptr_inc(hi_wr_q) : hi_wr_q;
    hi_rd_d  = pop_hi ? ptr_inc(hi_rd_q) : hi_rd_q;
    lo_wr_d  = wr_lo  ? ptr_inc(lo_wr_q) : lo_wr_q;
    lo_rd_d  = pop_lo ? ptr_inc(lo_rd_q) : lo_rd_q;
    hi_cnt_d = hi_cnt_q + OCC_W'(wr_hi) - OCC_W'(pop_hi);
    lo_cnt_d = lo_cnt_q + OCC_W'(wr_lo) - OCC_W'(pop_lo);

    // A packet popped in the detection cycle is delivered, not dropped.
    drop_add = ADD_W'(hi_cnt_q) + ADD_W'(lo_cnt_q) - ADD_W'(pop_hi) - ADD_W'(pop_lo);
    drop_sum = SUM_W'(drop_q) + SUM_W'(drop_add);
    drop_d   = drop_q;
    if (flush) begin
      hi_wr_d  = '0;
      hi_rd_d  = '0;
      hi_cnt_d = '0;
      lo_wr_d  = '0;
      lo_rd_d  = '0;
      lo_cnt_d = '0;
      drop_d   = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
    end

    starve_d = starve_q;
    if (!lo_ne || pop_lo) begin
      starve_d = '0;
    end else if (pop_hi && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 8'd1;
    end

    out_vld_d = out_vld_q;
    out_pkt_d = out_pkt_q;
    if (bypass) begin
      out_vld_d = 1'b1;
      out_pkt_d = in_pkt;
    end else if (pop_lo) begin
      out_vld_d = 1'b1;
      out_pkt_d = lo_mem_q[lo_rd_q];
    end else if (pop_hi) begin
      out_vld_d = 1'b1;
      out_pkt_d = hi_mem_q[hi_rd_q];
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  // Storage needs no reset; occupancy counters define validity.
  always_ff @(posedge clk) begin
    if (wr_hi) hi_mem_q[hi_wr_q] <= in_pkt;
    if (wr_lo) lo_mem_q[lo_wr_q] <= in_pkt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_wr_q   <= '0;
      hi_rd_q   <= '0;
      hi_cnt_q  <= '0;
      lo_wr_q   <= '0;
      lo_rd_q   <= '0;
      lo_cnt_q  <= '0;
      out_vld_q <= 1'b0;
      out_pkt_q <= '0;
      starve_q  <= '0;
      drop_q    <= '0;
      link_q    <= 1'b0;
    end else begin
      hi_wr_q   <= hi_wr_d;
      hi_rd_q   <= hi_rd_d;
      hi_cnt_q  <= hi_cnt_d;
      lo_wr_q   <= lo_wr_d;
      lo_rd_q   <= lo_rd_d;
      lo_cnt_q  <= lo_cnt_d;
      out_vld_q <= out_vld_d;
      out_pkt_q <= out_pkt_d;
      starve_q  <= starve_d;
      drop_q    <= drop_d;
      link_q    <= link_en;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_pkt  = out_pkt_q;
  assign occ_hi   = hi_cnt_q;
  assign occ_lo   = lo_cnt_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_mesh_link_qbuf.sv
`timescale 1ns/1ps
module tb_mesh_link_qbuf;

  logic        clk = 1'b0;
  logic        rst_n;
  // Instance A: DEPTH 4, STARVE_MAX 2, flushing, 3-bit drop counter
  logic        a_link_en, a_in_vld, a_in_rdy, a_out_vld, a_out_rdy;
  logic [22:0] a_in_pkt, a_out_pkt;
  logic [2:0]  a_occ_hi, a_occ_lo, a_drop;
  // Instance B: DEPTH 3, non-flushing
  logic        b_link_en, b_in_vld, b_in_rdy, b_out_vld, b_out_rdy;
  logic [22:0] b_in_pkt, b_out_pkt;
  logic [1:0]  b_occ_hi, b_occ_lo;
  logic [15:0] b_drop;

  int checks = 0;
  int errors = 0;
  logic [22:0] qa[$];
  logic [22:0] qb[$];

  always #5 clk = ~clk;

  mesh_link_qbuf #(.DEPTH(4), .STARVE_MAX(2), .FLUSH_ON_DOWN(1), .CNT_W(3)) u_a (
    .clk(clk), .rst_n(rst_n), .link_en(a_link_en), .in_vld(a_in_vld), .in_pkt(a_in_pkt),
    .in_rdy(a_in_rdy), .out_vld(a_out_vld), .out_pkt(a_out_pkt), .out_rdy(a_out_rdy),
    .occ_hi(a_occ_hi), .occ_lo(a_occ_lo), .drop_cnt(a_drop));

  mesh_link_qbuf #(.DEPTH(3), .FLUSH_ON_DOWN(0)) u_b (
    .clk(clk), .rst_n(rst_n), .link_en(b_link_en), .in_vld(b_in_vld), .in_pkt(b_in_pkt),
    .in_rdy(b_in_rdy), .out_vld(b_out_vld), .out_pkt(b_out_pkt), .out_rdy(b_out_rdy),
    .occ_hi(b_occ_hi), .occ_lo(b_occ_lo), .drop_cnt(b_drop));

  function automatic logic [22:0] mk(input logic q, input logic [7:0] d);
    return {2'b00, q, 6'h01, 6'h02, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Drive one packet for one cycle; check in_rdy and record expected output.
  task automatic push(input bit sel, input logic [22:0] p, input bit exp_rdy, input bit enq);
    if (!sel) begin a_in_vld = 1'b1; a_in_pkt = p; end
    else      begin b_in_vld = 1'b1; b_in_pkt = p; end
    sample();
    if (!sel) chk("a_in_rdy", a_in_rdy, exp_rdy);
    else      chk("b_in_rdy", b_in_rdy, exp_rdy);
    if (exp_rdy && enq) begin
      if (!sel) qa.push_back(p);
      else      qb.push_back(p);
    end
    step();
    a_in_vld = 1'b0;
    b_in_vld = 1'b0;
  endtask

  // Scoreboard: every completed output handshake pops the expected packet.
  always @(negedge clk) begin
    if (rst_n && a_out_vld && a_out_rdy) begin
      checks++;
      assert (qa.size() != 0) else begin
        errors++;
        $error("FAIL a_out_unexpected observed=%0h expected=none", a_out_pkt);
      end
      if (qa.size() != 0) chk("a_out", a_out_pkt, qa.pop_front());
    end
    if (rst_n && b_out_vld && b_out_rdy) begin
      checks++;
      assert (qb.size() != 0) else begin
        errors++;
        $error("FAIL b_out_unexpected observed=%0h expected=none", b_out_pkt);
      end
      if (qb.size() != 0) chk("b_out", b_out_pkt, qb.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    a_link_en = 1'b1; a_in_vld = 1'b0; a_in_pkt = '0; a_out_rdy = 1'b0;
    b_link_en = 1'b1; b_in_vld = 1'b0; b_in_pkt = '0; b_out_rdy = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;

    // Reset state
    sample();
    chk("rst_out_vld", a_out_vld, 0);
    chk("rst_out_pkt", a_out_pkt, 0);
    chk("rst_occ_hi", a_occ_hi, 0);
    chk("rst_occ_lo", a_occ_lo, 0);
    chk("rst_drop", a_drop, 0);
    chk("rst_b_out_vld", b_out_vld, 0);
    chk("rst_in_rdy", a_in_rdy, 1);

    // Basic pass: one-cycle latency through an idle link
    step();
    a_out_rdy = 1'b1;
    push(0, mk(0, 8'hAA), 1, 1);
    sample();
    chk("basic_out_vld", a_out_vld, 1);
    chk("basic_out_pkt", a_out_pkt, mk(0, 8'hAA));
    chk("basic_occ_lo", a_occ_lo, 0);

    // Backpressure: 1 in output reg, 4 in FIFO, 6th refused
    step();
    a_out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) push(0, mk(1, 8'h10 + 8'(i)), 1, 1);
    push(0, mk(1, 8'h15), 0, 0);
    sample();
    chk("bp_occ_hi", a_occ_hi, 4);
    chk("bp_hold_vld", a_out_vld, 1);
    chk("bp_hold_pkt", a_out_pkt, mk(1, 8'h10));
    step();
    a_out_rdy = 1'b1;
    repeat (5) sample();
    chk("bp_drain_5cyc", qa.size(), 0);
    sample();
    chk("bp_idle_vld", a_out_vld, 0);
    chk("bp_idle_occ", a_occ_hi, 0);

    // Priority / starvation with STARVE_MAX=2
    step();
    a_out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) push(0, mk(1, 8'h20 + 8'(i)), 1, 0);
    push(0, mk(0, 8'h30), 1, 0);
    push(0, mk(0, 8'h31), 1, 0);
    qa.push_back(mk(1, 8'h20)); qa.push_back(mk(1, 8'h21)); qa.push_back(mk(1, 8'h22));
    qa.push_back(mk(0, 8'h30)); qa.push_back(mk(1, 8'h23)); qa.push_back(mk(1, 8'h24));
    qa.push_back(mk(0, 8'h31));
    a_out_rdy = 1'b1;
    repeat (7) sample();
    chk("prio_drain", qa.size(), 0);
    sample();
    chk("prio_idle_vld", a_out_vld, 0);

    // Flush on link down
    step();
    a_out_rdy = 1'b0;
    push(0, mk(1, 8'h40), 1, 1);
    for (int i = 1; i < 4; i++) push(0, mk(1, 8'h40 + 8'(i)), 1, 0);
    push(0, mk(0, 8'h50), 1, 0);
    push(0, mk(0, 8'h51), 1, 0);
    sample();
    chk("fl_pre_occ_hi", a_occ_hi, 3);
    chk("fl_pre_occ_lo", a_occ_lo, 2);
    step();
    a_link_en = 1'b0;
    sample();
    chk("fl_down_in_rdy", a_in_rdy, 0);
    step();
    sample();
    chk("fl_occ_hi", a_occ_hi, 0);
    chk("fl_occ_lo", a_occ_lo, 0);
    chk("fl_drop", a_drop, 5);
    chk("fl_hold_vld", a_out_vld, 1);
    chk("fl_hold_pkt", a_out_pkt, mk(1, 8'h40));

    // Second flush of 3 saturates the 3-bit counter
    step();
    a_link_en = 1'b1;
    a_out_rdy = 1'b1;
    sample();
    step();
    a_out_rdy = 1'b0;
    push(0, mk(1, 8'h60), 1, 1);
    for (int i = 1; i < 4; i++) push(0, mk(1, 8'h60 + 8'(i)), 1, 0);
    a_link_en = 1'b0;
    step();
    sample();
    chk("sat_drop", a_drop, 7);
    chk("sat_occ_hi", a_occ_hi, 0);
    step();
    a_link_en = 1'b1;
    a_out_rdy = 1'b1;
    sample();
    step();
    a_out_rdy = 1'b0;
    chk("sat_drained", qa.size(), 0);

    // Instance B: hold on link down, link-up readiness, DEPTH=3 wrap
    for (int i = 0; i < 4; i++) push(1, mk(1, 8'h80 + 8'(i)), 1, 1);
    push(1, mk(1, 8'h84), 0, 0);
    sample();
    chk("b_occ_full", b_occ_hi, 3);
    step();
    b_link_en = 1'b0;
    sample();
    chk("b_down_in_rdy", b_in_rdy, 0);
    step();
    sample();
    chk("b_hold_occ", b_occ_hi, 3);
    chk("b_hold_drop", b_drop, 0);
    step();
    b_link_en = 1'b1;
    b_in_pkt = mk(0, 8'h00);
    sample();
    chk("b_up_in_rdy", b_in_rdy, 1);
    step();
    b_out_rdy = 1'b1;
    step();
    for (int i = 0; i < 8; i++) push(1, mk(0, 8'h90 + 8'(i)), 1, 1);
    for (int i = 0; i < 12 && qb.size() != 0; i++) sample();
    chk("b_drain", qb.size(), 0);
    sample();
    chk("b_idle_vld", b_out_vld, 0);

    // Asynchronous reset mid-cycle
    step();
    b_out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) push(0, mk(1, 8'h70 + 8'(i)), 1, 0);
    sample();
    chk("ar_pre_occ_hi", a_occ_hi, 2);
    chk("ar_pre_vld", a_out_vld, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_vld", a_out_vld, 0);
    chk("ar_occ_hi", a_occ_hi, 0);
    chk("ar_drop", a_drop, 0);
    chk("ar_out_pkt", a_out_pkt, 0);
    qa.delete();
    qb.delete();
    step();
    step();
    rst_n = 1'b1;
    sample();
    chk("ar_post_in_rdy", a_in_rdy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
